// File: rtl/memory_store_pkg.sv
// rtl/memory_store_pkg.sv - shared size-mode and FSM state encodings for the store path
// Mode encodings are one-hot and identical to the load-side select.
package memory_store_pkg;

    localparam logic [2:0] MODE_B = 3'b001;
    localparam logic [2:0] MODE_H = 3'b010;
    localparam logic [2:0] MODE_W = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

endpackage

// File: rtl/memory_store_align.sv
// rtl/memory_store_align.sv - combinational lane/strobe alignment for a store
// Ports:
//   data    in  32  right-justified store data
//   mode    in  3   one-hot size (byte/half/word)
//   off     in  2   byte offset within the word
//   data64  out 64  lane image across two consecutive words
//   strobe8 out 8   byte enables across two consecutive words
//   illegal out 1   mode is not one of the three legal one-hot codes
module memory_store_align
    import memory_store_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  mode,
    input  logic [1:0]  off,
    output logic [63:0] data64,
    output logic [7:0]  strobe8,
    output logic        illegal
);

    logic [3:0]  mask;
    logic [31:0] data_sized;

    always_comb begin
        mask       = 4'b0000;
        data_sized = 32'h0;
        illegal    = 1'b0;
        case (mode)
            MODE_B: begin
                mask       = 4'b0001;
                data_sized = {24'h0, data[7:0]};
            end
            MODE_H: begin
                mask       = 4'b0011;
                data_sized = {16'h0, data[15:0]};
            end
            MODE_W: begin
                mask       = 4'b1111;
                data_sized = data;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Upper halves of the images spill into the next word for split stores.
    assign strobe8 = {4'b0000, mask} << off;
    assign data64  = {32'h0, data_sized} << {off, 3'b000};

endmodule

// File: rtl/memory_store.sv
// rtl/memory_store.sv - store request to word-aligned bus beats with byte strobes
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           store request handshake (ready only in IDLE)
//   req_addr, req_data, req_mode  byte address, right-justified data, one-hot size
//   mem_valid/mem_ready           bus beat handshake
//   mem_addr, mem_wdata, mem_wstrb word address, lane data, byte enables
//   done, err                     completion pulse, err qualifies illegal mode
module memory_store
    import memory_store_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_mode,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    logic [1:0]  state;
    logic [31:0] data_hi;
    logic [3:0]  strb_hi;

    logic [63:0] al_data64;
    logic [7:0]  al_strobe8;
    logic        al_illegal;

    memory_store_align u_align (
        .data    (req_data),
        .mode    (req_mode),
        .off     (req_addr[1:0]),
        .data64  (al_data64),
        .strobe8 (al_strobe8),
        .illegal (al_illegal)
    );

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_hi   <= 32'h0;
            strb_hi   <= 4'h0;
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (al_illegal) begin
                            // Reject without touching the bus.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state     <= ST_BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= al_data64[31:0];
                            mem_wstrb <= al_strobe8[3:0];
                            data_hi   <= al_data64[63:32];
                            strb_hi   <= al_strobe8[7:4];
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
                        if (strb_hi != 4'h0) begin
                            state     <= ST_BEAT1;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_wdata <= data_hi;
                            mem_wstrb <= strb_hi;
                        end else begin
                            state     <= ST_IDLE;
                            mem_valid <= 1'b0;
                            mem_addr  <= 32'h0;
                            mem_wdata <= 32'h0;
                            mem_wstrb <= 4'h0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ready) begin
                        state     <= ST_IDLE;
                        mem_valid <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'h0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_valid <= 1'b0;
                    mem_addr  <= 32'h0;
                    mem_wdata <= 32'h0;
                    mem_wstrb <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_store.sv
// tb/tb_memory_store.sv - directed scoreboard bench for memory_store
module tb_memory_store;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_mode;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    beat_t sb[$];

    memory_store dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bench model: place each data byte into its lane independently, then
    // push one expected beat per word that has any enabled byte.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] m, input int stall);
        int          n;
        logic [31:0] wd [2];
        logic [3:0]  st [2];
        beat_t       bt;
        n = (m == 3'b001) ? 1 : (m == 3'b010) ? 2 : (m == 3'b100) ? 4 : 0;
        wd[0] = 32'h0; wd[1] = 32'h0;
        st[0] = 4'h0;  st[1] = 4'h0;
        for (int i = 0; i < n; i++) begin
            int p;
            p = int'(a[1:0]) + i;
            wd[p / 4][8 * (p % 4) +: 8] = d[8 * i +: 8];
            st[p / 4][p % 4] = 1'b1;
        end
        for (int b = 0; b < 2; b++) begin
            if (st[b] != 4'h0) begin
                bt.addr  = (a & 32'hFFFF_FFFC) + 32'(4 * b);
                bt.wdata = wd[b];
                bt.strb  = st[b];
                sb.push_back(bt);
            end
        end

        mem_ready = (stall == 0);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_mode  = m;
        @(negedge clk);
        req_valid = 1'b0;

        if (n == 0) begin
            chk("illegal_no_valid", {31'h0, mem_valid}, 32'h0);
            chk("illegal_done", {31'h0, done}, 32'h1);
            chk("illegal_err", {31'h0, err}, 32'h1);
            @(negedge clk);
            chk("illegal_done_clr", {31'h0, done}, 32'h0);
            chk("illegal_err_clr", {31'h0, err}, 32'h0);
            return;
        end

        while (sb.size() > 0) begin
            bt = sb.pop_front();
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) mem_ready = 1'b1;
                chk("beat_valid", {31'h0, mem_valid}, 32'h1);
                chk("beat_addr", mem_addr, bt.addr);
                chk("beat_wdata", mem_wdata, bt.wdata);
                chk("beat_wstrb", {28'h0, mem_wstrb}, {28'h0, bt.strb});
                chk("beat_no_done", {31'h0, done}, 32'h0);
                @(negedge clk);
            end
            if (stall != 0) mem_ready = 1'b0;
        end
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("done_err", {31'h0, err}, 32'h0);
        chk("done_idle_valid", {31'h0, mem_valid}, 32'h0);
        chk("done_idle_addr", mem_addr, 32'h0);
        chk("done_idle_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("done_req_ready", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_data    = 32'h0;
        req_mode    = 3'b000;
        mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        do_store(32'h0000_1003, 32'hAABB_CC5A, 3'b001, 0);
        do_store(32'h0000_2002, 32'h0000_BEEF, 3'b010, 0);
        do_store(32'h0000_3001, 32'h1122_3344, 3'b100, 0);
        do_store(32'hFFFF_FFFF, 32'h0000_1234, 3'b010, 3);
        do_store(32'h0000_0010, 32'hDEAD_BEEF, 3'b011, 0);
        do_store(32'h0000_0020, 32'hDEAD_BEEF, 3'b000, 0);
        do_store(32'h0000_5002, 32'hA1B2_C3D4, 3'b100, 1);
        do_store(32'h0000_6003, 32'h5566_7788, 3'b100, 0);
        do_store(32'h0000_7001, 32'hFFFF_99E7, 3'b010, 2);
        do_store(32'h0000_8002, 32'h0000_0042, 3'b001, 0);

        // Reset while BEAT1 is stalled.
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3001;
        req_data  = 32'h1122_3344;
        req_mode  = 3'b100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_beat0_wstrb", {28'h0, mem_wstrb}, 32'hE);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rstmid_beat1_valid", {31'h0, mem_valid}, 32'h1);
        chk("rstmid_beat1_addr", mem_addr, 32'h0000_3004);
        rst = 1'b1;
        #1;
        chk("rstmid_valid_drop", {31'h0, mem_valid}, 32'h0);
        chk("rstmid_addr_zero", mem_addr, 32'h0);
        chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        chk("rstmid_no_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_no_done_after", {31'h0, done}, 32'h0);
        do_store(32'h0000_4000, 32'hCAFE_F00D, 3'b100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
